miriscv_irq_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the core's interrupt inputs. It arbitrates up to N_IRQ peripheral request lines against the core's `mie` mask and drives the core's `int_i`/`mcause_i`. It consumes the core's `int_rst_o` and returns a one-cycle acknowledge to the serviced source. Arbitration is a round-robin scan counter, so no source can starve another.

---
 rtl/miriscv_irq_pkg.sv | 21 ++
 rtl/miriscv_irq_edge_det.sv | 30 +++
 rtl/miriscv_irq_ctrl.sv | 105 ++++++++++
 tb/tb_miriscv_irq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/miriscv_irq_pkg.sv
// Shared types and helpers for the miriscv interrupt controller.
// Cause-word layout: bit 31 flags an interrupt, bits 4:0 carry the source id.
package miriscv_irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ACK    = 2'd2
  } irq_state_t;

  localparam int MCAUSE_IRQ_BIT = 31;

  function automatic logic [31:0] irq_mcause(input logic [4:0] id);
    logic [31:0] w;
    w                 = 32'h0;
    w[MCAUSE_IRQ_BIT] = 1'b1;
    w[4:0]            = id;
    return w;
  endfunction

endpackage

// File: rtl/miriscv_irq_edge_det.sv
// Rising-edge capture of peripheral requests into a sticky pending register.
// Only built when MIRISCV_IRQ_EDGE_CAPTURE_EN is defined; set wins over clear.
module miriscv_irq_edge_det #(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] clr_i,
  output logic [N_IRQ-1:0] pend_o
);

  logic [N_IRQ-1:0] r_req_d;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] w_rise;

  assign w_rise = irq_req_i & ~r_req_d;
  assign pend_o = r_pend;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_req_d <= '0;
      r_pend  <= '0;
    end else begin
      r_req_d <= irq_req_i;
      r_pend  <= (r_pend & ~clr_i) | w_rise;
    end
  end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Round-robin interrupt controller in front of the miriscv core interrupt port.
// Define MIRISCV_IRQ_EDGE_CAPTURE_EN for edge-captured (sticky) requests; default is level.
module miriscv_irq_ctrl
  import miriscv_irq_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o
);

  localparam int CW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_id;
  logic [N_IRQ-1:0] w_src;
  logic [N_IRQ-1:0] w_act;
  logic [N_IRQ-1:0] w_id_oh;
  logic [4:0]       w_cnt5;
  logic [CW-1:0]    w_id_nxt;

  generate
    if (N_IRQ < 32) begin : g_mie_unused
      logic w_unused_mie;
      assign w_unused_mie = ^mie_i[31:N_IRQ];
    end
  endgenerate

`ifdef MIRISCV_IRQ_EDGE_CAPTURE_EN
  logic [N_IRQ-1:0] w_pend;
  logic [N_IRQ-1:0] w_clr;

  // The serviced source's pending bit drops in the ACK cycle.
  assign w_clr = (r_state == ACK) ? w_id_oh : '0;

  miriscv_irq_edge_det #(
    .N_IRQ (N_IRQ)
  ) u_edge_det (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .irq_req_i (irq_req_i),
    .clr_i     (w_clr),
    .pend_o    (w_pend)
  );

  assign w_src = w_pend;
`else
  assign w_src = irq_req_i;
`endif

  assign w_act    = w_src & mie_i[N_IRQ-1:0];
  assign w_cnt5   = 5'(r_cnt);
  assign w_id_nxt = (r_id == CW'(N_IRQ - 1)) ? '0 : r_id + 1'b1;

  always_comb begin
    w_id_oh       = '0;
    w_id_oh[r_id] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_id      <= '0;
      int_o     <= 1'b0;
      mcause_o  <= 32'h0;
      irq_ret_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_act[r_cnt]) begin
            r_id     <= r_cnt;
            int_o    <= 1'b1;
            mcause_o <= irq_mcause(w_cnt5);
            r_state  <= ACTIVE;
          end else begin
            r_cnt <= (r_cnt == CW'(N_IRQ - 1)) ? '0 : r_cnt + 1'b1;
          end
        end
        // Committed to r_id: only the core's end-of-service releases it.
        ACTIVE: begin
          if (int_rst_i) begin
            int_o     <= 1'b0;
            irq_ret_o <= w_id_oh;
            r_state   <= ACK;
          end
        end
        ACK: begin
          irq_ret_o <= '0;
          r_cnt     <= w_id_nxt;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Scoreboard bench for miriscv_irq_ctrl: expected cause/ack words are queued
// as stimulus is applied and popped when the controller raises int_o / irq_ret_o.
module tb_miriscv_irq_ctrl;

  localparam int N = 16;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic [N-1:0]  irq_req_i;
  logic [31:0]   mie_i;
  logic          int_rst_i;
  logic          int_o;
  logic [31:0]   mcause_o;
  logic [N-1:0]  irq_ret_o;

  int n_tot = 0;
  int n_bad = 0;
  int n_rise = 0;
  logic r_prev_int = 1'b0;

  logic [31:0] q_cause[$];
  logic [N-1:0] q_ret[$];

  miriscv_irq_ctrl #(.N_IRQ(N)) dut (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .irq_req_i (irq_req_i),
    .mie_i     (mie_i),
    .int_rst_i (int_rst_i),
    .int_o     (int_o),
    .mcause_o  (mcause_o),
    .irq_ret_o (irq_ret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each int_o rise and each ack pulse.
  always @(negedge clk_i) begin
    if (!arstn_i) begin
      r_prev_int = 1'b0;
    end else begin
      if (int_o && !r_prev_int) begin
        n_rise++;
        if (q_cause.size() == 0) chk("unexp_int", mcause_o, 32'h0);
        else                     chk("mcause", mcause_o, q_cause.pop_front());
      end
      if (irq_ret_o != '0) begin
        if (q_ret.size() == 0) chk("unexp_ret", 32'(irq_ret_o), 32'h0);
        else                   chk("irq_ret", 32'(irq_ret_o), 32'(q_ret.pop_front()));
      end
      r_prev_int = int_o;
    end
  end

  task automatic wait_int(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (!int_o && k < max_cyc) begin
      @(negedge clk_i);
      k++;
    end
    chk(tag, 32'(int_o), 32'h1);
  endtask

  // One-cycle end-of-service pulse; ack is checked by the monitor.
  task automatic service();
    @(negedge clk_i) int_rst_i = 1'b1;
    @(negedge clk_i) int_rst_i = 1'b0;
    chk("int_fall", 32'(int_o), 32'h0);
    @(negedge clk_i);
    chk("ret_1cyc", 32'(irq_ret_o), 32'h0);
  endtask

  task automatic latency_src3(input string tag);
    q_cause.push_back(32'h8000_0003);
    q_ret.push_back(16'h0008);
    irq_req_i = 16'h0008;
    mie_i     = 32'h8;
    @(negedge clk_i) arstn_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 chk({tag, "_e3"}, 32'(int_o), 32'h0);
    @(posedge clk_i);
    #1 chk({tag, "_e4"}, 32'(int_o), 32'h1);
    service();
    irq_req_i = '0;
  endtask

  logic [4:0] rr_exp [4] = '{5'd2, 5'd5, 5'd2, 5'd5};

  initial begin
    int base;
    arstn_i   = 1'b0;
    irq_req_i = '0;
    mie_i     = '0;
    int_rst_i = 1'b0;

    // Reset state
    #12;
    chk("rst_int", 32'(int_o), 32'h0);
    chk("rst_mcause", mcause_o, 32'h0);
    chk("rst_ret", 32'(irq_ret_o), 32'h0);

    // Single source 3, latency from reset release
    latency_src3("single");

    // Masked source never fires, then fires once enabled
    irq_req_i = 16'h0001;
    mie_i     = 32'h0;
    base      = n_rise;
    repeat (40) @(negedge clk_i);
    chk("mask_quiet", 32'(n_rise - base), 32'h0);
    q_cause.push_back(32'h8000_0000);
    q_ret.push_back(16'h0001);
    mie_i = 32'h1;
    wait_int(17, "mask_en");
    service();
    irq_req_i = '0;

    // Round-robin between sources 2 and 5
    mie_i = 32'h24;
    for (int i = 0; i < 4; i++) begin
      q_cause.push_back({27'h400_0000, rr_exp[i]});
      q_ret.push_back(16'(1) << rr_exp[i]);
    end
    irq_req_i = 16'h0024;
    for (int i = 0; i < 4; i++) begin
      wait_int(40, "rr_wait");
      chk("rr_order", 32'(mcause_o[4:0]), 32'(rr_exp[i]));
      service();
      irq_req_i[rr_exp[i]] = 1'b0;
      @(negedge clk_i);
      if (i < 2) irq_req_i[rr_exp[i]] = 1'b1;
    end
    irq_req_i = '0;

    // Commitment: request drops while ACTIVE, service continues
    mie_i = 32'h8;
    q_cause.push_back(32'h8000_0003);
    q_ret.push_back(16'h0008);
    irq_req_i = 16'h0008;
    wait_int(40, "commit_wait");
    irq_req_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("commit_hold", 32'(int_o), 32'h1);
    end
    service();

    // Asynchronous reset mid-ACTIVE
    q_cause.push_back(32'h8000_0003);
    irq_req_i = 16'h0008;
    wait_int(40, "arst_wait");
    @(negedge clk_i);
    #2 arstn_i = 1'b0;
    #1;
    chk("arst_int", 32'(int_o), 32'h0);
    chk("arst_mcause", mcause_o, 32'h0);
    chk("arst_ret", 32'(irq_ret_o), 32'h0);
    irq_req_i = '0;
    @(negedge clk_i);
    latency_src3("restart");

    // Single-cycle pulse on source 7 with cnt at 0
    arstn_i = 1'b0;
    @(negedge clk_i);
    mie_i = 32'h80;
    base  = n_rise;
    @(negedge clk_i);
    arstn_i      = 1'b1;
    irq_req_i[7] = 1'b1;
    @(negedge clk_i) irq_req_i[7] = 1'b0;
`ifdef MIRISCV_IRQ_EDGE_CAPTURE_EN
    q_cause.push_back(32'h8000_0007);
    q_ret.push_back(16'h0080);
    wait_int(20, "pulse_int");
    service();
`else
    repeat (20) @(negedge clk_i);
    chk("pulse_lost", 32'(n_rise - base), 32'h0);
`endif

    repeat (3) @(negedge clk_i);
    chk("sb_empty", 32'(q_cause.size() + q_ret.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
